act_relu_quant: RTL
===================

// Module: act_relu_quant
// PURPOSE
//  Single-lane activation stage directly upstream of the pooling lane; instantiated once per pooling lane.
//  Takes signed partial sums from the systolic-array accumulator and adds a per-channel bias.
//  Applies ReLU, then requantizes with a rounding right shift and unsigned saturation to DATA_WIDTH.
//  Emits act_valid/act_last/act_result/act_result_address, with the address generated by an internal counter.
// PARAMETERS
//  IN_WIDTH       24  width of signed psum_i and bias_i
//  DATA_WIDTH      8  width of unsigned act_result_o
//  ADDRESS_WIDTH  10  width of act_result_address_o and cfg_base_addr_i
//  SHIFT_WIDTH     5  width of cfg_shift_i (shift 0..2^SHIFT_WIDTH-1)
// PORTS
//  clk                   in   1              clock, all logic on rising edge
//  rst                   in   1              asynchronous reset, active-high
//  start_i               in   1              1-cycle pulse: latch cfg_*, load address counter, enter RUN
//  cfg_shift_i           in   SHIFT_WIDTH    requant right-shift amount, sampled on start_i
//  cfg_bias_i            in   IN_WIDTH       signed bias, sampled on start_i
//  cfg_base_addr_i       in   ADDRESS_WIDTH  first output address, sampled on start_i
//  psum_valid_i          in   1              psum_i/psum_last_i valid this cycle
//  psum_last_i           in   1              marks final psum of the tile
//  psum_i                in   IN_WIDTH       signed partial sum
//  act_last_o            out  1              final result of the tile
//  act_valid_o           out  1              act_result_o/act_result_address_o valid
//  act_result_o          out  DATA_WIDTH     unsigned activation
//  act_result_address_o  out  ADDRESS_WIDTH  output-buffer address of act_result_o
//  busy_o                out  1              high in RUN and DRAIN
// BEHAVIOUR
//  Reset: all outputs are 0, FSM is IDLE, pipeline valid bits are 0, and cfg registers are 0.
//  FSM:
//   IDLE -start_i-> RUN
//   RUN -accepted beat with psum_last_i-> DRAIN
//   DRAIN -last beat leaves stage 2-> IDLE
//  Acceptance:
//   A beat is accepted only when psum_valid_i=1 and state=RUN.
//   psum_valid_i in IDLE or DRAIN is dropped and produces no output.
//   start_i outside IDLE is ignored, and cfg is not re-sampled.
//   start_i and psum_valid_i in the same cycle in IDLE: start is taken and the psum is dropped.
//  No backpressure: downstream always accepts.
//  Pipeline, fixed latency 2 cycles (accept in cycle N -> act_valid_o in N+2):
//   Stage 1: sum = sign-extended psum_i + cfg_bias, in IN_WIDTH+1 bits, with no overflow possible.
//            The stage also registers the address and the last flag.
//   Stage 2: if sum <= 0, the result is 0 (ReLU).
//            Otherwise r = (sum + (shift ? 1<<(shift-1) : 0)) >>> shift, using round-half-up.
//            If r > 2^DATA_WIDTH-1, the result is 2^DATA_WIDTH-1 (saturate).
//  Address: the counter is loaded with cfg_base_addr_i on start_i and increments by 1 per accepted beat.
//   It wraps modulo 2^ADDRESS_WIDTH (1023 -> 0); wrap is not an error.
//  act_last_o: asserted with act_valid_o on the beat that carried psum_last_i. It is 0 whenever act_valid_o=0.
//  Output regs: act_* hold their last value when act_valid_o=0. Consumers qualify data with act_valid_o.
//  busy_o falls in the same cycle act_last_o is driven, so a new start_i is legal that cycle.
//  Reset mid-operation: the in-flight beats are discarded, no act_valid_o appears after reset, and the state is IDLE.
// TESTING
//  T1 reset: assert rst mid-tile with 2 beats in flight.
//     -> All outputs are 0 next cycle, no stray act_valid_o, busy_o=0.
//  T2 basic: start(shift=4, bias=8, base=100), then psum = 24, -50, 4088 (last).
//     -> act_valid_o at accept+2.
//     -> (result, address) = (2, 100), (0, 101), (255, 102); act_last_o on the 3rd beat only.
//  T3 rounding: shift=1, bias=0, psum=3 -> 2; psum=1 -> 1. Shift=0, psum=200 -> 200; psum=256 -> 255.
//  T4 address wrap: base=1022, 4 beats.
//     -> Addresses 1022, 1023, 0, 1; last beat flagged.
//  T5 gating: psum_valid_i in IDLE, in DRAIN, and coincident with start_i -> no output for any of them.
//     start_i during RUN with new cfg -> old cfg still used.
//  T6 back-to-back: new start_i in the cycle act_last_o=1.
//     -> Second tile streams with its own base/shift, no gap or overlap corruption, busy_o re-asserts.

Source files
------------

// File: rtl/act_relu_quant.sv
// Activation stage: psum + bias, ReLU, rounding right shift, unsigned saturation.
// Two-stage pipeline with an internal output-address counter and IDLE/RUN/DRAIN sequencing.
module act_relu_quant #(
  parameter int IN_WIDTH      = 24,
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 10,
  parameter int SHIFT_WIDTH   = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic [SHIFT_WIDTH-1:0]   cfg_shift_i,
  input  logic [IN_WIDTH-1:0]      cfg_bias_i,
  input  logic [ADDRESS_WIDTH-1:0] cfg_base_addr_i,
  input  logic                     psum_valid_i,
  input  logic                     psum_last_i,
  input  logic [IN_WIDTH-1:0]      psum_i,
  output logic                     act_last_o,
  output logic                     act_valid_o,
  output logic [DATA_WIDTH-1:0]    act_result_o,
  output logic [ADDRESS_WIDTH-1:0] act_result_address_o,
  output logic                     busy_o
);

  localparam int SUM_W  = IN_WIDTH + 1;
  // Wide enough that sum plus the largest rounding constant never overflows.
  localparam int WIDE_W = SUM_W + (1 << SHIFT_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [SHIFT_WIDTH-1:0]   shift_q, shift_d;
  logic [IN_WIDTH-1:0]      bias_q, bias_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;

  logic                     s1_valid_q, s1_valid_d;
  logic                     s1_last_q, s1_last_d;
  logic [SUM_W-1:0]         s1_sum_q, s1_sum_d;
  logic [ADDRESS_WIDTH-1:0] s1_addr_q, s1_addr_d;

  logic                     act_valid_q, act_valid_d;
  logic                     act_last_q, act_last_d;
  logic [DATA_WIDTH-1:0]    act_result_q, act_result_d;
  logic [ADDRESS_WIDTH-1:0] act_addr_q, act_addr_d;

  logic                     start_s;
  logic                     accept_s;
  logic [WIDE_W-1:0]        wide_s;
  logic [WIDE_W-1:0]        rnd_s;
  logic [WIDE_W-1:0]        shifted_s;
  logic [DATA_WIDTH-1:0]    result_s;

  assign start_s  = start_i && (state_q == ST_IDLE);
  assign accept_s = psum_valid_i && (state_q == ST_RUN);

  // Sequencing: DRAIN ends as the last beat moves into the output registers.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_RUN;
        else         state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (accept_s && psum_last_i) state_d = ST_DRAIN;
        else                         state_d = ST_RUN;
      end
      ST_DRAIN: begin
        if (s1_valid_q && s1_last_q) state_d = ST_IDLE;
        else                         state_d = ST_DRAIN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    shift_d = shift_q;
    bias_d  = bias_q;
    addr_d  = addr_q;
    if (start_s) begin
      shift_d = cfg_shift_i;
      bias_d  = cfg_bias_i;
      addr_d  = cfg_base_addr_i;
    end else if (accept_s) begin
      addr_d  = addr_q + ADDRESS_WIDTH'(1);
    end else begin
      addr_d  = addr_q;
    end
  end

  always_comb begin
    s1_valid_d = accept_s;
    s1_last_d  = accept_s && psum_last_i;
    s1_sum_d   = s1_sum_q;
    s1_addr_d  = s1_addr_q;
    if (accept_s) begin
      s1_sum_d  = {psum_i[IN_WIDTH-1], psum_i} + {bias_q[IN_WIDTH-1], bias_q};
      s1_addr_d = addr_q;
    end else begin
      s1_sum_d  = s1_sum_q;
      s1_addr_d = s1_addr_q;
    end
  end

  // Stage 2 arithmetic: non-positive sums clamp to zero before rounding.
  always_comb begin
    wide_s    = '0;
    rnd_s     = '0;
    shifted_s = '0;
    result_s  = '0;
    if (s1_sum_q[SUM_W-1] || (s1_sum_q == '0)) begin
      result_s = '0;
    end else begin
      wide_s = {{(WIDE_W-SUM_W){1'b0}}, s1_sum_q};
      if (shift_q != '0) begin
        rnd_s = {{(WIDE_W-1){1'b0}}, 1'b1} << (shift_q - SHIFT_WIDTH'(1));
      end else begin
        rnd_s = '0;
      end
      shifted_s = (wide_s + rnd_s) >> shift_q;
      if (|shifted_s[WIDE_W-1:DATA_WIDTH]) begin
        result_s = '1;
      end else begin
        result_s = shifted_s[DATA_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    act_valid_d  = s1_valid_q;
    act_last_d   = s1_valid_q && s1_last_q;
    act_result_d = act_result_q;
    act_addr_d   = act_addr_q;
    if (s1_valid_q) begin
      act_result_d = result_s;
      act_addr_d   = s1_addr_q;
    end else begin
      act_result_d = act_result_q;
      act_addr_d   = act_addr_q;
    end
  end

  // State, configuration, pipeline and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      bias_q       <= '0;
      addr_q       <= '0;
      s1_valid_q   <= 1'b0;
      s1_last_q    <= 1'b0;
      s1_sum_q     <= '0;
      s1_addr_q    <= '0;
      act_valid_q  <= 1'b0;
      act_last_q   <= 1'b0;
      act_result_q <= '0;
      act_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bias_q       <= bias_d;
      addr_q       <= addr_d;
      s1_valid_q   <= s1_valid_d;
      s1_last_q    <= s1_last_d;
      s1_sum_q     <= s1_sum_d;
      s1_addr_q    <= s1_addr_d;
      act_valid_q  <= act_valid_d;
      act_last_q   <= act_last_d;
      act_result_q <= act_result_d;
      act_addr_q   <= act_addr_d;
    end
  end

  assign act_valid_o          = act_valid_q;
  assign act_last_o           = act_last_q;
  assign act_result_o         = act_result_q;
  assign act_result_address_o = act_addr_q;
  assign busy_o               = (state_q != ST_IDLE);

endmodule
